// File: rtl/pout_led_pwm_if.sv
// naive_bus: SoC interconnect port with independent read and write
// request/grant channels, 32-bit address and data.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/pout_led_pwm.sv
// pout_led_pwm: WIDTH-channel output port with set/clear/toggle writes,
// per-channel blink from a shared prescaler and global PWM dimming.
module pout_led_pwm #(
    parameter int WIDTH   = 32,
    parameter int DIV_W   = 24,
    parameter int PWM_W   = 8,
    parameter int DIV_RST = 12_499_999
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] led,
    naive_bus.slave          bus
);

    typedef enum logic [2:0] {
        R_OUT  = 3'd0,
        R_SET  = 3'd1,
        R_CLR  = 3'd2,
        R_TGL  = 3'd3,
        R_MODE = 3'd4,
        R_DIV  = 3'd5,
        R_DUTY = 3'd6,
        R_STAT = 3'd7
    } reg_e;

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] mode_r;
    logic [DIV_W-1:0] div_r;
    logic [PWM_W-1:0] duty_r;
    logic [DIV_W-1:0] div_cnt;
    logic             blink_phase;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;
    logic [31:0]      rd_mux;
    logic [31:0]      rd_data_r;

    reg_e             rd_sel;
    reg_e             wr_sel;
    logic [WIDTH-1:0] wdat;
    logic             wr_div;

    assign bus.wr_gnt  = bus.wr_req;
    assign bus.rd_gnt  = bus.rd_req;
    assign bus.rd_data = rd_data_r;

    assign rd_sel = reg_e'(bus.rd_addr[4:2]);
    assign wr_sel = reg_e'(bus.wr_addr[4:2]);
    assign wdat   = bus.wr_data[WIDTH-1:0];
    assign wr_div = bus.wr_req && (wr_sel == R_DIV);

    always_comb begin
        out_nxt = out_r;
        if (bus.wr_req) begin
            unique case (wr_sel)
                R_OUT:   out_nxt = wdat;
                R_SET:   out_nxt = out_r | wdat;
                R_CLR:   out_nxt = out_r & ~wdat;
                R_TGL:   out_nxt = out_r ^ wdat;
                default: out_nxt = out_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= '0;
            mode_r <= '0;
            div_r  <= DIV_INIT;
            duty_r <= '1;
        end else begin
            out_r <= out_nxt;
            if (bus.wr_req && wr_sel == R_MODE)
                mode_r <= wdat;
            if (wr_div)
                div_r <= bus.wr_data[DIV_W-1:0];
            if (bus.wr_req && wr_sel == R_DUTY)
                duty_r <= bus.wr_data[PWM_W-1:0];
        end
    end

    // A BLINK_DIV write restarts the blink cycle and beats a same-cycle expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= DIV_INIT;
            blink_phase <= 1'b1;
        end else if (wr_div) begin
            div_cnt     <= bus.wr_data[DIV_W-1:0];
            blink_phase <= 1'b1;
        end else if (div_cnt == '0) begin
            div_cnt     <= div_r;
            blink_phase <= ~blink_phase;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign pwm_on = (&duty_r) | (pwm_cnt < duty_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led <= '0;
        else
            led <= out_r
                 & (~mode_r | {WIDTH{blink_phase}})
                 & {WIDTH{pwm_on}};
    end

    always_comb begin
        rd_mux = '0;
        unique case (rd_sel)
            R_OUT, R_SET, R_CLR, R_TGL:
                rd_mux[WIDTH-1:0] = out_r;
            R_MODE:
                rd_mux[WIDTH-1:0] = mode_r;
            R_DIV:
                rd_mux[DIV_W-1:0] = div_r;
            R_DUTY:
                rd_mux[PWM_W-1:0] = duty_r;
            R_STAT: begin
                rd_mux[0]         = blink_phase;
                rd_mux[PWM_W+7:8] = pwm_cnt;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_r <= '0;
        else if (bus.rd_req)
            rd_data_r <= rd_mux;
    end

endmodule

// File: tb/tb_pout_led_pwm.sv
// tb_pout_led_pwm: directed and random bus traffic against a
// time-based reference model of the LED/PWM peripheral (WIDTH=8).
module tb_pout_led_pwm;

    localparam int W       = 8;
    localparam int DIV_W   = 24;
    localparam int PWM_W   = 8;
    localparam int DIV_RST = 12_499_999;
    localparam logic [31:0] WMASK = 32'h0000_00FF;
    localparam logic [31:0] DMASK = 32'h00FF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] led;

    naive_bus bus_if ();

    pout_led_pwm #(
        .WIDTH  (W),
        .DIV_W  (DIV_W),
        .PWM_W  (PWM_W),
        .DIV_RST(DIV_RST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .led  (led),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: registers plus elapsed-time counters.
    logic [31:0] m_out, m_mode, m_div, m_duty, m_rd, m_led;
    longint      m_t;
    longint      m_cyc;

    function automatic logic m_phase();
        return ((m_t / (longint'(m_div) + 1)) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [2:0] s;
        s = a[4:2];
        case (s)
            3'd0, 3'd1, 3'd2, 3'd3: return m_out;
            3'd4: return m_mode;
            3'd5: return m_div;
            3'd6: return m_duty;
            default: return 32'((m_cyc % 256) << 8) | 32'(m_phase());
        endcase
    endfunction

    task automatic m_reset();
        m_out  = 0;
        m_mode = 0;
        m_div  = DIV_RST & DMASK;
        m_duty = 32'hFF;
        m_rd   = 0;
        m_led  = 0;
        m_t    = 0;
        m_cyc  = 0;
    endtask

    task automatic m_edge();
        logic        ph;
        logic        on;
        logic [31:0] nled;
        logic [31:0] wd;
        logic [2:0]  s;
        logic        divw;
        ph   = m_phase();
        on   = (m_duty == 32'hFF) || ((m_cyc % 256) < longint'(m_duty));
        nled = on ? (m_out & (ph ? WMASK : ~m_mode) & WMASK) : 32'h0;
        if (bus_if.rd_req)
            m_rd = m_read(bus_if.rd_addr);
        divw = 1'b0;
        if (bus_if.wr_req) begin
            wd = bus_if.wr_data;
            s  = bus_if.wr_addr[4:2];
            case (s)
                3'd0: m_out = wd & WMASK;
                3'd1: m_out = (m_out | wd) & WMASK;
                3'd2: m_out = m_out & ~wd & WMASK;
                3'd3: m_out = (m_out ^ wd) & WMASK;
                3'd4: m_mode = wd & WMASK;
                3'd5: begin m_div = wd & DMASK; divw = 1'b1; end
                3'd6: m_duty = wd & 32'hFF;
                default: ;
            endcase
        end
        m_t   = divw ? 0 : m_t + 1;
        m_led = nled;
        m_cyc = m_cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("led", 32'(led), m_led);
        chk("rd_data", bus_if.rd_data, m_rd);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic xfer(input logic rd, input logic [31:0] ra,
                        input logic wr, input logic [31:0] wa,
                        input logic [31:0] wd);
        bus_if.rd_req  = rd;
        bus_if.rd_addr = ra;
        bus_if.wr_req  = wr;
        bus_if.wr_addr = wa;
        bus_if.wr_data = wd;
        #1;
        chk("rd_gnt", 32'(bus_if.rd_gnt), 32'(rd));
        chk("wr_gnt", 32'(bus_if.wr_gnt), 32'(wr));
        step();
        bus_if.rd_req = 1'b0;
        bus_if.wr_req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        xfer(1'b0, 32'h0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(1'b1, a, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic reset_readback();
        logic [31:0] exp_rst [7];
        exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'(DIV_RST) & DMASK, 32'hFF};
        rd(32'h1C);
        chk("rst_status", bus_if.rd_data, 32'h1);
        for (int a = 0; a < 7; a++) begin
            rd(32'(a * 4));
            chk("rst_reg", bus_if.rd_data, exp_rst[a]);
        end
    endtask

    initial begin
        int          hi;
        int          hi1;
        logic [31:0] ra, wa, wd;
        logic        rq, wq;

        bus_if.rd_req  = 1'b0;
        bus_if.rd_addr = '0;
        bus_if.wr_req  = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        m_reset();
        #12;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_rd_data", bus_if.rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        reset_readback();

        wr(32'h0, 32'h0000_00F0);
        wr(32'h4, 32'h0F);
        wr(32'h8, 32'h30);
        wr(32'hC, 32'h81);
        idle(1);
        chk("led_after_tgl", 32'(led), 32'h4E);
        rd(32'h0);
        chk("out_rb", bus_if.rd_data, 32'h4E);
        rd(32'hC);
        chk("tgl_rb", bus_if.rd_data, 32'h4E);

        wr(32'h10, 32'h1);
        wr(32'h0, 32'h3);
        wr(32'h14, 32'h3);
        hi1 = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("blink0", 32'(led[0]), 32'(((k - 1) / 4) % 2 == 0));
            hi1 += int'(led[1]);
        end
        chk("steady1", 32'(hi1), 32'd32);

        wr(32'h10, 32'h0);
        wr(32'h0, 32'h1);
        wr(32'h18, 32'h40);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            hi += int'(led[0]);
        end
        chk("pwm_40", 32'(hi), 32'd64);
        wr(32'h18, 32'h0);
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            hi += int'(led[0]);
        end
        chk("pwm_00", 32'(hi), 32'd0);
        wr(32'h18, 32'hFF);
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            hi += int'(led[0]);
        end
        chk("pwm_ff", 32'(hi), 32'd64);

        wr(32'h0, 32'hFFFF_FFFF);
        rd(32'h0);
        chk("out_mask", bus_if.rd_data, 32'hFF);
        wr(32'h10, 32'hFFFF_FF00);
        rd(32'h10);
        chk("mode_mask", bus_if.rd_data, 32'h0);
        wr(32'h1C, 32'hDEAD_BEEF);
        for (int a = 0; a < 7; a++) begin
            rd(32'(a * 4));
            chk("stat_wr_ignored", bus_if.rd_data, m_read(32'(a * 4)));
        end
        rd(32'h0);
        chk("out_after_stat", bus_if.rd_data, 32'hFF);
        xfer(1'b1, 32'h0, 1'b1, 32'h0, 32'h5A);
        chk("rw_old", bus_if.rd_data, 32'hFF);
        rd(32'hE3);
        chk("rw_new", bus_if.rd_data, 32'h5A);

        for (int k = 0; k < 1500; k++) begin
            rq = 1'($urandom);
            wq = 1'($urandom);
            ra = $urandom;
            wa = $urandom;
            wd = (wa[4:2] == 3'd5) ? $urandom_range(0, 6) : $urandom;
            xfer(rq, ra, wq, wa, wd);
        end

        wr(32'h10, 32'h1);
        wr(32'h0, 32'h1);
        wr(32'h14, 32'h1);
        wr(32'h18, 32'h80);
        rd(32'h18);
        idle(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_led", 32'(led), 32'h0);
        chk("async_rd_data", bus_if.rd_data, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        reset_readback();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pout_led_pwm.md
# pout_led_pwm

Parametrised LED/parallel-output peripheral on the SoC `naive_bus`. It generalises the single 32-bit write-only LED register to WIDTH channels with full readback and atomic set/clear/toggle writes. Each channel can also blink from a shared programmable prescaler, and all outputs are dimmed by a global PWM duty. It sits on a bus slave port of the SoC interconnect and drives board LEDs or general-purpose outputs.

## Interface
- WIDTH, 32: number of output channels, 1..32; register bits above WIDTH-1 read 0 and ignore writes.
- DIV_W, 24: width of the blink prescaler.
- PWM_W, 8: width of the PWM counter and duty register.
- DIV_RST, 12_499_999: reset value of BLINK_DIV, truncated to DIV_W.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- led  out  WIDTH  registered channel outputs.
- bus  naive_bus.slave  -  `rd_req/rd_gnt/rd_addr/rd_data`, `wr_req/wr_gnt/wr_addr/wr_data`, 32-bit data.

## Operation
- Register select is `addr[4:2]`; `addr[1:0]` and bits above 4 are ignored.
  - 0 OUT (RW): channel enables.
  - 1 SET (W): `OUT |= wdata`.
  - 2 CLR (W): `OUT &= ~wdata`.
  - 3 TGL (W): `OUT ^= wdata`.
  - 4 MODE (RW): per channel, 0 = steady, 1 = blink.
  - 5 BLINK_DIV (RW): prescaler reload value, DIV_W bits.
  - 6 DUTY (RW): PWM duty, PWM_W bits.
  - 7 STATUS (RO): bit0 = blink_phase, bits[PWM_W+7:8] = pwm_cnt.
- Reads of SET, CLR and TGL return OUT. Writes to STATUS are granted and ignored.
- Blink prescaler:
  - div_cnt counts down each cycle.
  - When div_cnt == 0, it reloads BLINK_DIV and blink_phase toggles.
  - BLINK_DIV = 0 toggles the phase every cycle; period = 2·(BLINK_DIV+1) cycles.
  - Any write to BLINK_DIV loads div_cnt with the new value and forces blink_phase = 1 on the same edge.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit counter that wraps from all-ones to 0.
  - pwm_on = (DUTY == all-ones) | (pwm_cnt < DUTY). DUTY = 0 gives always off; all-ones gives always on.
- Output: `led[i] <= OUT[i] & (MODE[i] ? blink_phase : 1) & pwm_on`, registered.
- Reset values:
  - Registers: OUT = 0, MODE = 0, BLINK_DIV = DIV_RST, DUTY = all-ones.
  - Counters and phase: div_cnt = DIV_RST, blink_phase = 1, pwm_cnt = 0.
  - Outputs: led = 0, rd_data = 0.
- Asserting rst_n mid-operation clears all state immediately, regardless of clk.

## Timing
- `wr_gnt = wr_req` and `rd_gnt = rd_req`, both combinational; the block never stalls.
- A write accepted at edge N updates the register at edge N. led reflects the change at edge N+1.
- Read data is registered: `rd_data` is valid the cycle after `rd_gnt` and holds until the next granted read.
- A simultaneous read and write to the same register returns the old value.
- A write to BLINK_DIV and a prescaler expiry in the same cycle: the write wins, so div_cnt = new value and phase = 1.
- A DUTY write takes effect on pwm_on from the next cycle. pwm_cnt is not reset by the write.

## Test plan
- Reset, then read all 8 addresses -> `OUT=0`, `MODE=0`, `BLINK_DIV=DIV_RST`, `DUTY=0xFF`, `STATUS=0x1`; led = 0.
- Write `OUT=0x0000_00F0`, then SET `0x0F`, then CLR `0x30`, then TGL `0x81` -> OUT reads `0x4E`; led = `0x4E` one cycle after the last write.
- Set `MODE=0x1`, `OUT=0x3`, `BLINK_DIV=3` -> led[0] alternates 4 cycles high, 4 cycles low; led[1] stays 1.
- Set `DUTY=0x40`, `OUT=1` -> led[0] is high exactly 64 of every 256 cycles. `DUTY=0` -> always 0. `DUTY=0xFF` -> always 1.
- With WIDTH=8, write `OUT=0xFFFF_FFFF` -> readback `0xFF`. Write to address `0x1C` (STATUS) -> no register changes.
- Assert rst_n asynchronously while blinking at `DUTY=0x80` -> led = 0 and all registers return to reset values before the next clk edge.
